io_port_bridge: RTL and testbench

//  Host-side end of the processor's read_in/write_out I/O interface.

---
 rtl/io_port_bridge.sv | 115 +++++++++++
 tb/tb_io_port_bridge.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/io_port_bridge.sv
// Host-side bridge for the processor read_in/write_out interface.
// An input FIFO feeds read_in and an output FIFO captures write_out; the host drains it.
module io_port_bridge #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AW     = 2
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [DATA_W-1:0] host_in_data,
    input  logic              host_in_valid,
    output logic              host_in_ready,
    output logic [DATA_W-1:0] read_in,
    output logic              read_in_valid,
    input  logic              in_consume,
    input  logic [DATA_W-1:0] write_out,
    input  logic              out_we,
    output logic [DATA_W-1:0] host_out_data,
    output logic              host_out_valid,
    input  logic              host_out_ready,
    output logic [AW:0]       in_count,
    output logic [AW:0]       out_count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AW:0]   DepthCnt = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CntOne   = (AW+1)'(1);
    localparam logic [AW-1:0] PtrOne   = AW'(1);

    logic [DATA_W-1:0] in_mem  [DEPTH];
    logic [DATA_W-1:0] out_mem [DEPTH];

    logic [AW-1:0] in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
    logic [AW-1:0] out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
    logic [AW:0]   in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic          overflow_q, overflow_d, underflow_q, underflow_d;

    logic in_push, in_pop, out_push, out_pop, out_full;

    assign host_in_ready  = (in_cnt_q != DepthCnt);
    assign read_in_valid  = (in_cnt_q != '0);
    assign host_out_valid = (out_cnt_q != '0);
    assign out_full       = (out_cnt_q == DepthCnt);

    assign in_push  = host_in_valid & host_in_ready;
    assign in_pop   = in_consume & read_in_valid;
    assign out_pop  = host_out_valid & host_out_ready;
    // A full output FIFO still accepts a word when the host frees a slot this cycle.
    assign out_push = out_we & (~out_full | out_pop);

    assign read_in       = read_in_valid  ? in_mem[in_rptr_q]   : '0;
    assign host_out_data = host_out_valid ? out_mem[out_rptr_q] : '0;
    assign in_count      = in_cnt_q;
    assign out_count     = out_cnt_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

    always_comb begin
        in_wptr_d   = in_wptr_q;
        in_rptr_d   = in_rptr_q;
        in_cnt_d    = in_cnt_q;
        out_wptr_d  = out_wptr_q;
        out_rptr_d  = out_rptr_q;
        out_cnt_d   = out_cnt_q;
        overflow_d  = overflow_q | (out_we & out_full & ~out_pop);
        underflow_d = underflow_q | (in_consume & ~read_in_valid);

        if (in_push)  in_wptr_d  = in_wptr_q + PtrOne;
        if (in_pop)   in_rptr_d  = in_rptr_q + PtrOne;
        if (out_push) out_wptr_d = out_wptr_q + PtrOne;
        if (out_pop)  out_rptr_d = out_rptr_q + PtrOne;

        case ({in_push, in_pop})
            2'b10:   in_cnt_d = in_cnt_q + CntOne;
            2'b01:   in_cnt_d = in_cnt_q - CntOne;
            default: in_cnt_d = in_cnt_q;
        endcase

        case ({out_push, out_pop})
            2'b10:   out_cnt_d = out_cnt_q + CntOne;
            2'b01:   out_cnt_d = out_cnt_q - CntOne;
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            in_wptr_q   <= '0;
            in_rptr_q   <= '0;
            in_cnt_q    <= '0;
            out_wptr_q  <= '0;
            out_rptr_q  <= '0;
            out_cnt_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            in_wptr_q   <= in_wptr_d;
            in_rptr_q   <= in_rptr_d;
            in_cnt_q    <= in_cnt_d;
            out_wptr_q  <= out_wptr_d;
            out_rptr_q  <= out_rptr_d;
            out_cnt_q   <= out_cnt_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (!rst && in_push)  in_mem[in_wptr_q]   <= host_in_data;
        if (!rst && out_push) out_mem[out_wptr_q] <= write_out;
    end

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed self-checking bench for io_port_bridge.
// Inputs change and outputs are checked 1ns after each rising edge.
module tb_io_port_bridge;

    logic        clock = 1'b0;
    logic        rst;
    logic [15:0] host_in_data;
    logic        host_in_valid;
    logic        host_in_ready;
    logic [15:0] read_in;
    logic        read_in_valid;
    logic        in_consume;
    logic [15:0] write_out;
    logic        out_we;
    logic [15:0] host_out_data;
    logic        host_out_valid;
    logic        host_out_ready;
    logic [2:0]  in_count;
    logic [2:0]  out_count;
    logic        overflow;
    logic        underflow;

    int errors = 0;
    int checks = 0;

    io_port_bridge #(.DATA_W(16), .DEPTH(4), .AW(2)) dut (
        .clock          (clock),
        .rst            (rst),
        .host_in_data   (host_in_data),
        .host_in_valid  (host_in_valid),
        .host_in_ready  (host_in_ready),
        .read_in        (read_in),
        .read_in_valid  (read_in_valid),
        .in_consume     (in_consume),
        .write_out      (write_out),
        .out_we         (out_we),
        .host_out_data  (host_out_data),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .in_count       (in_count),
        .out_count      (out_count),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst            = 1'b1;
        host_in_data   = '0;
        host_in_valid  = 1'b0;
        in_consume     = 1'b0;
        write_out      = '0;
        out_we         = 1'b0;
        host_out_ready = 1'b0;

        // 1: reset
        repeat (5) tick();
        check("rst_read_in", 32'(read_in), 32'h0);
        check("rst_read_in_valid", 32'(read_in_valid), 32'h0);
        check("rst_host_out_data", 32'(host_out_data), 32'h0);
        check("rst_host_out_valid", 32'(host_out_valid), 32'h0);
        check("rst_host_in_ready", 32'(host_in_ready), 32'h1);
        check("rst_in_count", 32'(in_count), 32'h0);
        check("rst_out_count", 32'(out_count), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_underflow", 32'(underflow), 32'h0);
        rst = 1'b0;
        tick();

        // 2: two pushes, one consume
        host_in_data = 16'h13b4; host_in_valid = 1'b1;
        tick();
        check("t2_head_first", 32'(read_in), 32'h13b4);
        check("t2_valid_first", 32'(read_in_valid), 32'h1);
        check("t2_count_first", 32'(in_count), 32'h1);
        host_in_data = 16'h1234;
        tick();
        host_in_valid = 1'b0;
        check("t2_count_two", 32'(in_count), 32'h2);
        check("t2_head_still", 32'(read_in), 32'h13b4);
        in_consume = 1'b1;
        tick();
        in_consume = 1'b0;
        check("t2_head_after_pop", 32'(read_in), 32'h1234);
        check("t2_count_after_pop", 32'(in_count), 32'h1);
        in_consume = 1'b1;
        tick();
        in_consume = 1'b0;
        check("t2_empty_count", 32'(in_count), 32'h0);
        check("t2_empty_read_in", 32'(read_in), 32'h0);
        check("t2_no_underflow", 32'(underflow), 32'h0);

        // 3: fill input FIFO, reject 5th word, drain, then underflow
        host_in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            host_in_data = 16'(i);
            tick();
        end
        host_in_valid = 1'b0;
        check("t3_full_count", 32'(in_count), 32'h4);
        check("t3_full_ready", 32'(host_in_ready), 32'h0);
        host_in_data = 16'h0005; host_in_valid = 1'b1;
        tick();
        host_in_valid = 1'b0;
        check("t3_fifth_rejected", 32'(in_count), 32'h4);
        for (int i = 1; i <= 4; i++) begin
            check("t3_order", 32'(read_in), 32'(i));
            in_consume = 1'b1;
            tick();
            in_consume = 1'b0;
        end
        check("t3_drained_count", 32'(in_count), 32'h0);
        check("t3_drained_underflow", 32'(underflow), 32'h0);
        in_consume = 1'b1;
        tick();
        in_consume = 1'b0;
        check("t3_underflow", 32'(underflow), 32'h1);
        check("t3_underflow_count", 32'(in_count), 32'h0);

        // 4: output FIFO with host back-pressure
        host_out_ready = 1'b0;
        out_we = 1'b1; write_out = 16'h000b;
        tick();
        write_out = 16'h0003;
        tick();
        out_we = 1'b0;
        check("t4_count", 32'(out_count), 32'h2);
        check("t4_head", 32'(host_out_data), 32'h000b);
        check("t4_valid", 32'(host_out_valid), 32'h1);
        host_out_ready = 1'b1;
        tick();
        check("t4_second", 32'(host_out_data), 32'h0003);
        check("t4_count_one", 32'(out_count), 32'h1);
        tick();
        check("t4_empty_valid", 32'(host_out_valid), 32'h0);
        check("t4_empty_data", 32'(host_out_data), 32'h0);
        check("t4_empty_count", 32'(out_count), 32'h0);
        host_out_ready = 1'b0;

        // 5: overflow drop, then accepted write alongside a pop
        out_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            write_out = 16'h0010 + 16'(i);
            tick();
        end
        check("t5_full_count", 32'(out_count), 32'h4);
        check("t5_no_overflow", 32'(overflow), 32'h0);
        write_out = 16'h00ff;
        tick();
        check("t5_overflow", 32'(overflow), 32'h1);
        check("t5_drop_count", 32'(out_count), 32'h4);
        check("t5_drop_head", 32'(host_out_data), 32'h0010);
        write_out = 16'h00ee; host_out_ready = 1'b1;
        tick();
        out_we = 1'b0;
        check("t5_accept_count", 32'(out_count), 32'h4);
        check("t5_accept_head", 32'(host_out_data), 32'h0011);
        check("t5_overflow_sticky", 32'(overflow), 32'h1);
        check("t5_drain_0", 32'(host_out_data), 32'h0011);
        tick();
        check("t5_drain_1", 32'(host_out_data), 32'h0012);
        tick();
        check("t5_drain_2", 32'(host_out_data), 32'h0013);
        tick();
        check("t5_drain_3", 32'(host_out_data), 32'h00ee);
        tick();
        check("t5_drained_valid", 32'(host_out_valid), 32'h0);
        host_out_ready = 1'b0;

        // 6: reset mid-stream
        host_in_valid = 1'b1; out_we = 1'b1;
        host_in_data = 16'h00a1; write_out = 16'h00b1;
        tick();
        host_in_data = 16'h00a2; write_out = 16'h00b2;
        tick();
        host_in_valid = 1'b0; out_we = 1'b0;
        check("t6_pre_in_count", 32'(in_count), 32'h2);
        check("t6_pre_out_count", 32'(out_count), 32'h2);
        rst = 1'b1; host_in_valid = 1'b1; host_in_data = 16'h00a3;
        tick();
        rst = 1'b0; host_in_valid = 1'b0;
        check("t6_in_count", 32'(in_count), 32'h0);
        check("t6_out_count", 32'(out_count), 32'h0);
        check("t6_read_in_valid", 32'(read_in_valid), 32'h0);
        check("t6_host_out_valid", 32'(host_out_valid), 32'h0);
        check("t6_overflow", 32'(overflow), 32'h0);
        check("t6_underflow", 32'(underflow), 32'h0);
        check("t6_read_in", 32'(read_in), 32'h0);
        host_in_valid = 1'b1; host_in_data = 16'h00aa;
        out_we = 1'b1; write_out = 16'h00bb;
        tick();
        host_in_valid = 1'b0; out_we = 1'b0;
        check("t6_fresh_read_in", 32'(read_in), 32'h00aa);
        check("t6_fresh_in_count", 32'(in_count), 32'h1);
        check("t6_fresh_out_data", 32'(host_out_data), 32'h00bb);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
